// File: rtl/reg_pkg.sv
// Shared types for the register-file stage: request/response structs,
// stage FSM encoding, busy-vector type and the hazard check.
package reg_pkg;

  localparam int REG_NUM = 32;
  localparam int REG_AW  = $clog2(REG_NUM);
  localparam int XLEN    = 32;

  typedef logic [XLEN-1:0]   imm_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic {
    reg_idle = 1'b0,
    reg_next = 1'b1
  } reg_state_t;

  typedef struct packed {
    logic            valid;
    logic            pc_branch;
    logic            wb_wr;
    logic            alu_s1_font;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] pc;
  } fur_sig_t;

  typedef struct packed {
    reg_state_t state;
    reg_addr_t  addr_out1;
    reg_addr_t  addr_out2;
    reg_addr_t  reg_dst;
    fur_sig_t   fur_sig;
  } decoder_to_reg_req_t;

  typedef struct packed {
    imm_t     data_out1;
    imm_t     data_out2;
    fur_sig_t fur_sig;
  } reg_to_alu_info_t;

  typedef struct packed {
    logic      valid_in;
    reg_addr_t addr_in;
    imm_t      data_in;
    fur_sig_t  fur_sig;
  } wb_to_reg_req_t;

  typedef struct packed {
    fur_sig_t fur_sig;
  } wb_info_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } reg_stage_state_t;

  typedef logic [REG_NUM-1:0] busy_vec_t;

  // The destination only matters when the instruction will write it (WAW).
  function automatic logic has_hazard(input busy_vec_t busy, input busy_vec_t clr_vec,
                                      input reg_addr_t src1, input reg_addr_t src2,
                                      input reg_addr_t dst, input logic wb_wr);
    busy_vec_t blk;
    blk = busy & ~clr_vec;
    return blk[src1] | blk[src2] | (wb_wr & blk[dst]);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one bit per register with set-over-clear priority,
// flush-clear of the whole vector, and the decoder hazard output.
module reg_scoreboard
  import reg_pkg::*;
#(
  parameter bit ZERO_REG  = 1'b1,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_set_en,
  input  reg_addr_t i_set_addr,
  input  logic      i_clr_en,
  input  reg_addr_t i_clr_addr,
  input  logic      i_flush,
  input  reg_addr_t i_src1,
  input  reg_addr_t i_src2,
  input  reg_addr_t i_dst,
  input  logic      i_wb_wr,
  output logic      o_hazard
);

  busy_vec_t r_busy;
  busy_vec_t w_set_vec;
  busy_vec_t w_clr_vec;
  busy_vec_t w_busy_next;
  busy_vec_t w_bypass_clr;

  for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_bit
    localparam bit IS_ZERO = (gi == 0) && ZERO_REG;
    assign w_set_vec[gi]   = i_set_en && (i_set_addr == reg_addr_t'(gi)) && !IS_ZERO;
    assign w_clr_vec[gi]   = i_clr_en && (i_clr_addr == reg_addr_t'(gi));
    assign w_busy_next[gi] = i_flush ? 1'b0 : (w_set_vec[gi] | (r_busy[gi] & ~w_clr_vec[gi]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_next;
  end

  // Without bypass the writeback data is not visible yet, so the clear cannot unblock.
  assign w_bypass_clr = WB_BYPASS ? w_clr_vec : '0;
  assign o_hazard     = has_hazard(r_busy, w_bypass_clr, i_src1, i_src2, i_dst, i_wb_wr);

endmodule

// File: rtl/reg_file_stage.sv
// Register-file pipeline stage: register bank with writeback bypass, hazard
// stall toward the decoder, registered operands toward the ALU.
module reg_file_stage
  import reg_pkg::*;
#(
  parameter bit ZERO_REG  = 1'b1,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  decoder_to_reg_req_t dec_req,
  output logic                dec_stall,
  input  wb_to_reg_req_t      wb_req,
  output reg_to_alu_info_t    alu_info,
  output wb_info_t            wb_info
);

  imm_t             r_bank [REG_NUM];
  reg_to_alu_info_t r_alu_info;
  wb_info_t         r_wb_info;
  reg_stage_state_t r_state;
  logic [15:0]      r_stall_cnt;

  logic             w_present;
  logic             w_flush;
  logic             w_hazard;
  logic             w_issue;
  logic             w_wr_en;
  imm_t             w_data1;
  imm_t             w_data2;
  reg_to_alu_info_t w_alu_next;

  assign w_present = (dec_req.state == reg_next);
  assign w_flush   = wb_req.valid_in & wb_req.fur_sig.valid & wb_req.fur_sig.pc_branch;
  assign dec_stall = w_present & w_hazard & ~w_flush;
  assign w_issue   = w_present & ~dec_stall & ~w_flush;
  assign w_wr_en   = wb_req.valid_in & ~(ZERO_REG & (wb_req.addr_in == '0));

  // Operand priority: hardwired zero, then same-cycle writeback, then bank.
  assign w_data1 = (ZERO_REG && dec_req.addr_out1 == '0) ? '0 :
                   (WB_BYPASS && wb_req.valid_in && wb_req.addr_in == dec_req.addr_out1) ?
                   wb_req.data_in : r_bank[dec_req.addr_out1];
  assign w_data2 = (ZERO_REG && dec_req.addr_out2 == '0) ? '0 :
                   (WB_BYPASS && wb_req.valid_in && wb_req.addr_in == dec_req.addr_out2) ?
                   wb_req.data_in : r_bank[dec_req.addr_out2];

  reg_scoreboard #(
    .ZERO_REG  (ZERO_REG),
    .WB_BYPASS (WB_BYPASS)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_set_en   (w_issue & dec_req.fur_sig.wb_wr),
    .i_set_addr (dec_req.reg_dst),
    .i_clr_en   (wb_req.valid_in),
    .i_clr_addr (wb_req.addr_in),
    .i_flush    (w_flush),
    .i_src1     (dec_req.addr_out1),
    .i_src2     (dec_req.addr_out2),
    .i_dst      (dec_req.reg_dst),
    .i_wb_wr    (dec_req.fur_sig.wb_wr),
    .o_hazard   (w_hazard)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) r_bank[i] <= '0;
    end else if (w_wr_en) begin
      r_bank[wb_req.addr_in] <= wb_req.data_in;
    end
  end

  always_comb begin
    w_alu_next = '0;
    if (w_issue) begin
      w_alu_next.data_out1 = w_data1;
      w_alu_next.data_out2 = w_data2;
      w_alu_next.fur_sig   = dec_req.fur_sig;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_info <= '0;
      r_wb_info  <= '0;
    end else begin
      r_alu_info        <= w_alu_next;
      r_wb_info.fur_sig <= wb_req.fur_sig;
    end
  end

  // Stall-cycle counter for performance debug; saturates rather than wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
    end else begin
      case (r_state)
        RUN:     if (dec_stall) r_state <= STALL;
        STALL:   if (!dec_stall || w_flush) r_state <= RUN;
        default: r_state <= RUN;
      endcase
      if (r_state == STALL && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign alu_info = r_alu_info;
  assign wb_info  = r_wb_info;

endmodule
